// File: rtl/assp_pkfb_mux_fifo_pkg.sv
// Shared types and width helpers for the ASSP packet-FIFO mux.
// ASSP_PKFB_TIMESTAMP_EN adds a 24-bit push timestamp to every entry tag.
package assp_pkfb_pkg;

    localparam int TS_W = 24;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Entry tag; the payload is appended by the users since its width is a module parameter
    typedef struct packed {
        logic            sof;
        logic            eof;
`ifdef ASSP_PKFB_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
    } pkfb_tag_t;

    function automatic int ch_w_f(input int nch);
        if (nch <= 1) begin
            return 1;
        end else begin
            return $clog2(nch);
        end
    endfunction

    function automatic int cnt_w_f(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/assp_pkfb_mux_fifo_if.sv
// Push, drain and status bundle of the packet-FIFO mux.
// ASSP_PKFB_TIMESTAMP_EN adds TimeStamp / Rd_TimeStamp.
interface assp_pkfb_mux_fifo_if #(
    parameter int NCH    = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) ();
    import assp_pkfb_pkg::*;

    localparam int CH_W  = ch_w_f(NCH);
    localparam int CNT_W = cnt_w_f(DEPTH);

    logic [DATA_W-1:0]    FB_PKfbData;
    logic [NCH-1:0]       FB_PKfbPush;
    logic                 FB_PKfbSOF;
    logic                 FB_PKfbEOF;
    logic                 FB_PKfbOverflow;
    logic [NCH-1:0]       Ovf_Sticky;
    logic [NCH-1:0]       Ovf_Clr;
    logic [DATA_W-1:0]    Rd_Data;
    logic [CH_W-1:0]      Rd_Chan;
    logic                 Rd_SOF;
    logic                 Rd_EOF;
    logic                 Rd_Valid;
    logic                 Rd_Ready;
    logic [NCH*CNT_W-1:0] Fill_Lvl;
    logic [NCH-1:0]       SDMA_Req;
`ifdef ASSP_PKFB_TIMESTAMP_EN
    logic [TS_W-1:0]      TimeStamp;
    logic [TS_W-1:0]      Rd_TimeStamp;
`endif

    modport master (
        output FB_PKfbData, FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, Ovf_Clr, Rd_Ready,
`ifdef ASSP_PKFB_TIMESTAMP_EN
        input  TimeStamp, Rd_TimeStamp,
`endif
        input  FB_PKfbOverflow, Ovf_Sticky, Rd_Data, Rd_Chan, Rd_SOF, Rd_EOF,
        input  Rd_Valid, Fill_Lvl, SDMA_Req
    );

    modport slave (
        input  FB_PKfbData, FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, Ovf_Clr, Rd_Ready,
`ifdef ASSP_PKFB_TIMESTAMP_EN
        output TimeStamp, Rd_TimeStamp,
`endif
        output FB_PKfbOverflow, Ovf_Sticky, Rd_Data, Rd_Chan, Rd_SOF, Rd_EOF,
        output Rd_Valid, Fill_Lvl, SDMA_Req
    );

endinterface

// File: rtl/assp_pkfb_mux_fifo_chan_fifo.sv
// One channel's circular buffer. A push into a full buffer is still accepted
// when the head is popped on the same edge, since that frees exactly one slot.
module assp_pkfb_chan_fifo #(
    parameter int ENTRY_W = 34,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wr_entry,
    output logic [ENTRY_W-1:0] rd_entry,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               accept
);

    // Pointers carry one extra wrap bit so wr - rd is the occupancy directly
    logic [CNT_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_s;
    logic               full_s;
    logic               do_pop_s;
    logic               do_push_s;
    logic [ENTRY_W-1:0] mem_r [DEPTH];

    // Occupancy, full/empty and the accept decision
    always_comb begin
        count_s   = wr_ptr_r - rd_ptr_r;
        empty     = (count_s == '0);
        full_s    = (count_s == CNT_W'(DEPTH));
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full_s || do_pop_s);
    end

    assign count    = count_s;
    assign accept   = do_push_s;
    assign rd_entry = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer registers; reset discards everything still buffered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + CNT_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + CNT_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_entry;
        end
    end

endmodule

// File: rtl/assp_pkfb_mux_fifo.sv
// NCH packet FIFOs with overflow reporting and a packet-atomic round-robin drain.
// Optional: ASSP_PKFB_TIMESTAMP_EN stamps each entry with a free-running 24-bit counter.
module assp_pkfb_mux_fifo
    import assp_pkfb_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input logic                Sys_PKfb_Clk,
    input logic                Sys_PKfb_Rst,
    assp_pkfb_mux_fifo_if.slave bus
);

    localparam int CH_W  = ch_w_f(NCH);
    localparam int CNT_W = cnt_w_f(DEPTH);

    typedef struct packed {
        pkfb_tag_t         tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t                      wr_entry_s;
    entry_t                      rd_entry_s [NCH];
    entry_t                      head_s;
    entry_t                      rd_entry_r;
    logic [CNT_W-1:0]            count_s [NCH];
    logic [NCH-1:0]              empty_s;
    logic [NCH-1:0]              accept_s;
    logic [NCH-1:0]              pop_s;
    logic [NCH-1:0]              drop_s;
    logic [CH_W-1:0]             sel_s;
    logic [CH_W-1:0]             cand_s;
    logic                        sel_valid_s;
    logic                        load_s;
    arb_state_t                  arb_state_r;
    arb_state_t                  arb_state_s;
    logic [CH_W-1:0]             lock_ch_r;
    logic [CH_W-1:0]             lock_ch_s;
    logic [CH_W-1:0]             rr_ptr_r;
    logic                        rd_valid_r;
    logic [CH_W-1:0]             rd_chan_r;
    logic                        ovf_pulse_r;
    logic [NCH-1:0]              ovf_sticky_r;
    logic [NCH-1:0][CNT_W-1:0]   fill_lvl_r;
    logic [NCH-1:0]              sdma_req_r;

`ifdef ASSP_PKFB_TIMESTAMP_EN
    logic [TS_W-1:0]             ts_r;

    // Free-running timestamp, wraps naturally at 2^24
    always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
        if (Sys_PKfb_Rst) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    assign bus.TimeStamp    = ts_r;
    assign bus.Rd_TimeStamp = rd_entry_r.tag.ts;
`endif

    // The same entry is offered to every channel; each FIFO decides on its own strobe
    always_comb begin
        wr_entry_s         = '0;
        wr_entry_s.tag.sof = bus.FB_PKfbSOF;
        wr_entry_s.tag.eof = bus.FB_PKfbEOF;
`ifdef ASSP_PKFB_TIMESTAMP_EN
        wr_entry_s.tag.ts  = ts_r;
`endif
        wr_entry_s.data    = bus.FB_PKfbData;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assp_pkfb_chan_fifo #(
            .ENTRY_W (ENTRY_W),
            .DEPTH   (DEPTH)
        ) u_fifo (
            .clk      (Sys_PKfb_Clk),
            .rst      (Sys_PKfb_Rst),
            .push     (bus.FB_PKfbPush[g]),
            .pop      (pop_s[g]),
            .wr_entry (wr_entry_s),
            .rd_entry (rd_entry_s[g]),
            .count    (count_s[g]),
            .empty    (empty_s[g]),
            .accept   (accept_s[g])
        );
    end

    // Channel select: locked channel only, else first non-empty from rr_ptr_r upward
    always_comb begin
        sel_s       = rr_ptr_r;
        sel_valid_s = 1'b0;
        cand_s      = '0;
        if (arb_state_r == ARB_LOCKED) begin
            sel_s       = lock_ch_r;
            sel_valid_s = !empty_s[lock_ch_r];
        end else begin
            // Walk downward so the nearest candidate is the last one to win
            for (int i = NCH - 1; i >= 0; i--) begin
                cand_s = CH_W'((int'(rr_ptr_r) + i) % NCH);
                if (!empty_s[cand_s]) begin
                    sel_s       = cand_s;
                    sel_valid_s = 1'b1;
                end else begin
                    sel_valid_s = sel_valid_s;
                end
            end
        end
    end

    // Output-register load, per-channel pop and next lock state
    always_comb begin
        load_s      = (!rd_valid_r || bus.Rd_Ready) && sel_valid_s;
        head_s      = rd_entry_s[sel_s];
        pop_s       = '0;
        arb_state_s = arb_state_r;
        lock_ch_s   = lock_ch_r;
        for (int ch = 0; ch < NCH; ch++) begin
            pop_s[ch] = load_s && (sel_s == CH_W'(ch));
        end
        if (load_s) begin
            case ({head_s.tag.sof, head_s.tag.eof})
                2'b10: begin
                    arb_state_s = ARB_LOCKED;
                    lock_ch_s   = sel_s;
                end
                2'b01, 2'b11: arb_state_s = ARB_IDLE;
                default:      arb_state_s = arb_state_r;
            endcase
        end else begin
            arb_state_s = arb_state_r;
        end
    end

    // Lock state and round-robin pointer
    always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
        if (Sys_PKfb_Rst) begin
            arb_state_r <= ARB_IDLE;
            lock_ch_r   <= '0;
            rr_ptr_r    <= '0;
        end else begin
            arb_state_r <= arb_state_s;
            lock_ch_r   <= lock_ch_s;
            if (load_s) begin
                rr_ptr_r <= (sel_s == CH_W'(NCH - 1)) ? '0 : sel_s + CH_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Drain output register; contents held while stalled
    always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
        if (Sys_PKfb_Rst) begin
            rd_valid_r <= 1'b0;
            rd_entry_r <= '0;
            rd_chan_r  <= '0;
        end else if (load_s) begin
            rd_valid_r <= 1'b1;
            rd_entry_r <= head_s;
            rd_chan_r  <= sel_s;
        end else if (bus.Rd_Ready) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_valid_r;
        end
    end

    assign drop_s = bus.FB_PKfbPush & ~accept_s;

    // Overflow pulse and sticky flags; a new drop beats a same-cycle clear
    always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
        if (Sys_PKfb_Rst) begin
            ovf_pulse_r  <= 1'b0;
            ovf_sticky_r <= '0;
        end else begin
            ovf_pulse_r  <= |drop_s;
            ovf_sticky_r <= (ovf_sticky_r & ~bus.Ovf_Clr) | drop_s;
        end
    end

    // Registered fill levels and DMA requests
    always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
        if (Sys_PKfb_Rst) begin
            fill_lvl_r <= '0;
            sdma_req_r <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                fill_lvl_r[ch] <= count_s[ch];
                sdma_req_r[ch] <= (count_s[ch] >= CNT_W'(THRESH));
            end
        end
    end

    assign bus.FB_PKfbOverflow = ovf_pulse_r;
    assign bus.Ovf_Sticky      = ovf_sticky_r;
    assign bus.Rd_Data         = rd_entry_r.data;
    assign bus.Rd_Chan         = rd_chan_r;
    assign bus.Rd_SOF          = rd_entry_r.tag.sof;
    assign bus.Rd_EOF          = rd_entry_r.tag.eof;
    assign bus.Rd_Valid        = rd_valid_r;
    assign bus.Fill_Lvl        = fill_lvl_r;
    assign bus.SDMA_Req        = sdma_req_r;

endmodule

// File: tb/tb_assp_pkfb_mux_fifo.sv
// Directed bench for assp_pkfb_mux_fifo: expected drain words are queued at stimulus
// time and a negedge monitor compares every accepted word against the queue.
module tb_assp_pkfb_mux_fifo;

    logic clk;
    logic rst;

    typedef struct packed {
        logic [1:0]  chan;
        logic        sof;
        logic        eof;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks;
    int   n_errors;
    int   ovf_pulses;
    int   ovf_base;

    assp_pkfb_mux_fifo_if #(.NCH(4), .DATA_W(32), .DEPTH(16)) bus ();

    assp_pkfb_mux_fifo #(
        .NCH    (4),
        .DATA_W (32),
        .DEPTH  (16),
        .THRESH (8)
    ) dut (
        .Sys_PKfb_Clk (clk),
        .Sys_PKfb_Rst (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every accepted drain word must match the queue head
    always @(negedge clk) begin
        exp_t got;
        exp_t req;
        if (!rst && bus.Rd_Valid && bus.Rd_Ready) begin
            got = {bus.Rd_Chan, bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL drain_unexpected: got chan=%0d sof=%0d eof=%0d data=%h, required no word",
                         got.chan, got.sof, got.eof, got.data);
            end else begin
                req = exp_q.pop_front();
                if (got !== req) begin
                    n_errors++;
                    $display("FAIL drain_word: got chan=%0d sof=%0d eof=%0d data=%h, required chan=%0d sof=%0d eof=%0d data=%h",
                             got.chan, got.sof, got.eof, got.data, req.chan, req.sof, req.eof, req.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.FB_PKfbOverflow) ovf_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    function automatic void sb_add(input logic [1:0] ch, input logic s, input logic e, input logic [31:0] d);
        exp_t x;
        x = {ch, s, e, d};
        exp_q.push_back(x);
    endfunction

    task automatic push(input logic [3:0] mask, input logic [31:0] d, input logic s, input logic e);
        bus.FB_PKfbPush = mask;
        bus.FB_PKfbData = d;
        bus.FB_PKfbSOF  = s;
        bus.FB_PKfbEOF  = e;
        tick();
        bus.FB_PKfbPush = 4'b0000;
        bus.FB_PKfbSOF  = 1'b0;
        bus.FB_PKfbEOF  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.Rd_Valid) && k < 200) begin
            tick();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.Rd_Valid) begin
            n_errors++;
            $display("FAIL %s_drain_timeout: got %0d words pending, required 0", name, exp_q.size());
        end
    endtask

    function automatic logic [4:0] fill(input int ch);
        return bus.Fill_Lvl[ch*5 +: 5];
    endfunction

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        ovf_pulses      = 0;
        rst             = 1'b1;
        bus.FB_PKfbData = 32'h0;
        bus.FB_PKfbPush = 4'b0000;
        bus.FB_PKfbSOF  = 1'b0;
        bus.FB_PKfbEOF  = 1'b0;
        bus.Ovf_Clr     = 4'b0000;
        bus.Rd_Ready    = 1'b0;
        tick(3);

        check("rst_rd_valid", 64'(bus.Rd_Valid), 64'd0);
        check("rst_rd_data", 64'(bus.Rd_Data), 64'd0);
        check("rst_rd_chan", 64'(bus.Rd_Chan), 64'd0);
        check("rst_fill_lvl", 64'(bus.Fill_Lvl), 64'd0);
        check("rst_sdma_req", 64'(bus.SDMA_Req), 64'd0);
        check("rst_ovf_sticky", 64'(bus.Ovf_Sticky), 64'd0);
        check("rst_overflow", 64'(bus.FB_PKfbOverflow), 64'd0);
        rst = 1'b0;
        tick(2);

        // Single-word packet on ch2: visible after the second edge
        bus.Rd_Ready = 1'b1;
        sb_add(2'd2, 1'b1, 1'b1, 32'hA5A5_0001);
        push(4'b0100, 32'hA5A5_0001, 1'b1, 1'b1);
        check("t1_valid_edge1", 64'(bus.Rd_Valid), 64'd0);
        tick();
        check("t1_valid_edge2", 64'(bus.Rd_Valid), 64'd1);
        tick(3);
        check("t1_fill_ch2", 64'(fill(2)), 64'd0);

        // Output register parked with a ch1 word, then fill ch0 past full
        bus.Rd_Ready = 1'b0;
        sb_add(2'd1, 1'b1, 1'b1, 32'h1111_0001);
        push(4'b0010, 32'h1111_0001, 1'b1, 1'b1);
        tick(2);
        for (int i = 0; i < 7; i++) begin
            sb_add(2'd0, 1'b1, 1'b1, 32'h0000_0100 + 32'(i));
            push(4'b0001, 32'h0000_0100 + 32'(i), 1'b1, 1'b1);
        end
        tick(2);
        check("t2_sdma_at7", 64'(bus.SDMA_Req[0]), 64'd0);
        check("t2_fill_at7", 64'(fill(0)), 64'd7);
        sb_add(2'd0, 1'b1, 1'b1, 32'h0000_0107);
        push(4'b0001, 32'h0000_0107, 1'b1, 1'b1);
        tick(2);
        check("t2_sdma_at8", 64'(bus.SDMA_Req[0]), 64'd1);
        check("t2_fill_at8", 64'(fill(0)), 64'd8);
        for (int i = 8; i < 16; i++) begin
            sb_add(2'd0, 1'b1, 1'b1, 32'h0000_0100 + 32'(i));
            push(4'b0001, 32'h0000_0100 + 32'(i), 1'b1, 1'b1);
        end
        tick(2);
        check("t2_fill_full", 64'(fill(0)), 64'd16);
        check("t2_no_ovf_yet", 64'(ovf_pulses), 64'd0);
        ovf_base = ovf_pulses;
        push(4'b0001, 32'h0000_DEAD, 1'b1, 1'b1);
        tick(2);
        check("t2_ovf_one_pulse", 64'(ovf_pulses - ovf_base), 64'd1);
        check("t2_ovf_sticky", 64'(bus.Ovf_Sticky), 64'h1);
        check("t2_fill_after_drop", 64'(fill(0)), 64'd16);
        bus.Ovf_Clr = 4'b0001;
        tick();
        bus.Ovf_Clr = 4'b0000;
        tick();
        check("t2_sticky_cleared", 64'(bus.Ovf_Sticky), 64'h0);
        bus.Rd_Ready = 1'b1;
        wait_drain("t2");

        // ch1 four-word packet interleaved with single-word ch3 packets
        sb_add(2'd1, 1'b1, 1'b0, 32'h1000_0000);
        sb_add(2'd1, 1'b0, 1'b0, 32'h1000_0001);
        sb_add(2'd1, 1'b0, 1'b0, 32'h1000_0002);
        sb_add(2'd1, 1'b0, 1'b1, 32'h1000_0003);
        sb_add(2'd3, 1'b1, 1'b1, 32'h3000_0001);
        sb_add(2'd3, 1'b1, 1'b1, 32'h3000_0002);
        sb_add(2'd3, 1'b1, 1'b1, 32'h3000_0003);
        push(4'b0010, 32'h1000_0000, 1'b1, 1'b0);
        push(4'b1000, 32'h3000_0001, 1'b1, 1'b1);
        push(4'b0010, 32'h1000_0001, 1'b0, 1'b0);
        push(4'b1000, 32'h3000_0002, 1'b1, 1'b1);
        push(4'b0010, 32'h1000_0002, 1'b0, 1'b0);
        push(4'b1000, 32'h3000_0003, 1'b1, 1'b1);
        push(4'b0010, 32'h1000_0003, 1'b0, 1'b1);
        wait_drain("t3");

        // One word in every channel, then refill ch0/ch1 after the pointer wraps
        for (int ch = 0; ch < 4; ch++) sb_add(2'(ch), 1'b1, 1'b1, 32'h4444_0000);
        push(4'b1111, 32'h4444_0000, 1'b1, 1'b1);
        wait_drain("t4a");
        sb_add(2'd0, 1'b1, 1'b1, 32'h5555_0000);
        sb_add(2'd1, 1'b1, 1'b1, 32'h5555_0000);
        push(4'b0011, 32'h5555_0000, 1'b1, 1'b1);
        wait_drain("t4b");

        // Full ch0 with a pop and a push on the same edge
        bus.Rd_Ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sb_add(2'd0, 1'b1, 1'b1, 32'h6000_0000 + 32'(i));
            push(4'b0001, 32'h6000_0000 + 32'(i), 1'b1, 1'b1);
        end
        tick(2);
        check("t5_fill_full", 64'(fill(0)), 64'd16);
        ovf_base = ovf_pulses;
        bus.Rd_Ready = 1'b1;
        sb_add(2'd0, 1'b1, 1'b1, 32'h6000_0011);
        push(4'b0001, 32'h6000_0011, 1'b1, 1'b1);
        bus.Rd_Ready = 1'b0;
        tick(2);
        check("t5_fill_stays_full", 64'(fill(0)), 64'd16);
        check("t5_no_overflow", 64'(ovf_pulses - ovf_base), 64'd0);
        check("t5_sticky_clear", 64'(bus.Ovf_Sticky), 64'h0);
        bus.Rd_Ready = 1'b1;
        wait_drain("t5");

        // Reset in the middle of a locked ch2 packet
        bus.Rd_Ready = 1'b0;
        push(4'b0100, 32'h7000_0000, 1'b1, 1'b0);
        push(4'b0100, 32'h7000_0001, 1'b0, 1'b0);
        tick();
        check("t6_valid_before_rst", 64'(bus.Rd_Valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_valid_async_drop", 64'(bus.Rd_Valid), 64'd0);
        check("t6_fill_cleared", 64'(bus.Fill_Lvl), 64'd0);
        check("t6_sdma_cleared", 64'(bus.SDMA_Req), 64'd0);
        tick(2);
        rst = 1'b0;
        tick();
        bus.Rd_Ready = 1'b1;
        sb_add(2'd3, 1'b0, 1'b1, 32'h8000_0001);
        sb_add(2'd1, 1'b1, 1'b1, 32'h8000_0002);
        push(4'b1000, 32'h8000_0001, 1'b0, 1'b1);
        push(4'b0010, 32'h8000_0002, 1'b1, 1'b1);
        wait_drain("t6");

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
